mem_port_arbiter: RTL and testbench

- Shares one single-ported instruction/data memory between the fetch stage (F) and the memory stage (M) of the 5-stage RISC-V pipeline.
- Sequences each access over a req/ack memory handshake with variable latency.
- Raises per-stage stall requests, which the hazard unit ORs into its existing stall and flush outputs.
- Adds a bounded-wait timeout and discards fetch responses that a flush has made obsolete.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_timeout_cnt.sv | 39 +++
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the F/M memory port arbiter: FSM encoding and the
// byte-enable fill used for instruction fetches.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        F_BUSY = 2'b01,
        M_BUSY = 2'b10
    } arb_state_e;

    // Fetches always read the whole word: every byte-enable bit takes this value.
    localparam logic DEFAULT_BE_BIT = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Busy-cycle counter for the memory arbiter; at_limit flags the last cycle
// in which an ack may still arrive before the access is abandoned.
module arb_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset_x,
    input  logic clr,
    input  logic en,
    output logic at_limit
);

    localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The counter reaches LIMIT at the edge that ends the access, so the
    // busy state lasts exactly LIMIT cycles without an ack.
    assign at_limit = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (F) and memory (M)
// pipeline stages over a req/ack handshake with timeout and fetch-flush drop.
module mem_port_arbiter
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_x,

    input  logic                Fi_req,
    input  logic [ADDR_W-1:0]   Fi_addr,
    input  logic                Fi_flush,
    output logic [DATA_W-1:0]   Fo_rdata,
    output logic                Fo_valid,
    output logic                Fo_memStall,

    input  logic                Mi_req,
    input  logic                Mi_we,
    input  logic [ADDR_W-1:0]   Mi_addr,
    input  logic [DATA_W-1:0]   Mi_wdata,
    input  logic [DATA_W/8-1:0] Mi_be,
    output logic [DATA_W-1:0]   Mo_rdata,
    output logic                Mo_valid,
    output logic                Mo_memStall,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                mem_err
);

    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_e          state_q,    state_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic [BE_W-1:0]     be_q,       be_d;
    logic                we_q,       we_d;
    logic [DATA_W-1:0]   fo_rdata_q, fo_rdata_d;
    logic [DATA_W-1:0]   mo_rdata_q, mo_rdata_d;
    logic                fo_valid_q, fo_valid_d;
    logic                mo_valid_q, mo_valid_d;
    logic                mem_err_q,  mem_err_d;
    logic                drop_q,     drop_d;

    logic busy;
    logic at_limit;
    logic m_elig;
    logic f_elig;
    logic drop_eff;

    assign busy     = (state_q != IDLE);
    // A port whose completion pulse is up still shows the finished request.
    assign m_elig   = Mi_req & ~mo_valid_q;
    assign f_elig   = Fi_req & ~fo_valid_q;
    assign drop_eff = drop_q | Fi_flush;

    arb_timeout_cnt #(
        .LIMIT (ACK_TIMEOUT)
    ) u_timeout_cnt (
        .clk      (clk),
        .reset_x  (reset_x),
        .clr      (~busy),
        .en       (busy & ~mem_ack),
        .at_limit (at_limit)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        fo_rdata_d = fo_rdata_q;
        mo_rdata_d = mo_rdata_q;
        fo_valid_d = 1'b0;
        mo_valid_d = 1'b0;
        mem_err_d  = 1'b0;
        drop_d     = drop_q;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (m_elig) begin
                    state_d = M_BUSY;
                    addr_d  = Mi_addr;
                    we_d    = Mi_we;
                    wdata_d = Mi_wdata;
                    be_d    = Mi_be;
                end else if (f_elig) begin
                    state_d = F_BUSY;
                    addr_d  = Fi_addr;
                    we_d    = 1'b0;
                    be_d    = {BE_W{DEFAULT_BE_BIT}};
                    drop_d  = Fi_flush;
                end
            end

            F_BUSY: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    // A flush arriving together with the ack still squashes it.
                    if (!drop_eff) begin
                        fo_valid_d = 1'b1;
                        fo_rdata_d = mem_rdata;
                    end
                end else if (at_limit) begin
                    state_d   = IDLE;
                    drop_d    = 1'b0;
                    mem_err_d = 1'b1;
                end else begin
                    drop_d = drop_eff;
                end
            end

            M_BUSY: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mo_valid_d = 1'b1;
                    mo_rdata_d = mem_rdata;
                end else if (at_limit) begin
                    state_d   = IDLE;
                    mem_err_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            fo_rdata_q <= '0;
            mo_rdata_q <= '0;
            fo_valid_q <= 1'b0;
            mo_valid_q <= 1'b0;
            mem_err_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            fo_rdata_q <= fo_rdata_d;
            mo_rdata_q <= mo_rdata_d;
            fo_valid_q <= fo_valid_d;
            mo_valid_q <= mo_valid_d;
            mem_err_q  <= mem_err_d;
            drop_q     <= drop_d;
        end
    end

    assign mem_req     = busy;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_be      = be_q;
    assign mem_err     = mem_err_q;

    assign Fo_rdata    = fo_rdata_q;
    assign Fo_valid    = fo_valid_q;
    assign Mo_rdata    = mo_rdata_q;
    assign Mo_valid    = mo_valid_q;

    assign Fo_memStall = Fi_req & ~fo_valid_q;
    assign Mo_memStall = Mi_req & ~mo_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter, built with a short ack timeout so the
// abort path and the ack-at-limit boundary are reachable in a few cycles.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              reset_x;
    logic              Fi_req;
    logic [ADDR_W-1:0] Fi_addr;
    logic              Fi_flush;
    logic [DATA_W-1:0] Fo_rdata;
    logic              Fo_valid;
    logic              Fo_memStall;
    logic              Mi_req;
    logic              Mi_we;
    logic [ADDR_W-1:0] Mi_addr;
    logic [DATA_W-1:0] Mi_wdata;
    logic [3:0]        Mi_be;
    logic [DATA_W-1:0] Mo_rdata;
    logic              Mo_valid;
    logic              Mo_memStall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              mem_err;

    int tests_run;
    int tests_failed;
    int txn_count;
    int txn_start;
    int req_cycles;

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset_x     (reset_x),
        .Fi_req      (Fi_req),
        .Fi_addr     (Fi_addr),
        .Fi_flush    (Fi_flush),
        .Fo_rdata    (Fo_rdata),
        .Fo_valid    (Fo_valid),
        .Fo_memStall (Fo_memStall),
        .Mi_req      (Mi_req),
        .Mi_we       (Mi_we),
        .Mi_addr     (Mi_addr),
        .Mi_wdata    (Mi_wdata),
        .Mi_be       (Mi_be),
        .Mo_rdata    (Mo_rdata),
        .Mo_valid    (Mo_valid),
        .Mo_memStall (Mo_memStall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial txn_count = 0;
    always @(posedge clk) begin
        if (reset_x && mem_req && mem_ack) txn_count <= txn_count + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_x   = 1'b1;
        Fi_req    = 1'b0;
        Fi_addr   = '0;
        Fi_flush  = 1'b0;
        Mi_req    = 1'b0;
        Mi_we     = 1'b0;
        Mi_addr   = '0;
        Mi_wdata  = '0;
        Mi_be     = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        #2 reset_x = 1'b0;
        tick;
        tick;
        check_eq("rst_mem_req",  32'(mem_req),  32'h0);
        check_eq("rst_fo_valid", 32'(Fo_valid), 32'h0);
        check_eq("rst_mo_valid", 32'(Mo_valid), 32'h0);
        check_eq("rst_mem_err",  32'(mem_err),  32'h0);
        check_eq("rst_fo_rdata", Fo_rdata,      32'h0);
        check_eq("rst_mo_rdata", Mo_rdata,      32'h0);
        check_eq("rst_mem_addr", mem_addr,      32'h0);
        reset_x = 1'b1;
        tick;

        // 1: single fetch, ack in the first mem_req cycle
        Fi_req  = 1'b1;
        Fi_addr = 32'h100;
        #1 check_eq("t1_stall_idle", 32'(Fo_memStall), 32'h1);
        tick;
        check_eq("t1_mem_req",  32'(mem_req),  32'h1);
        check_eq("t1_mem_addr", mem_addr,      32'h100);
        check_eq("t1_mem_we",   32'(mem_we),   32'h0);
        check_eq("t1_mem_be",   32'(mem_be),   32'hf);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0013;
        tick;
        mem_ack = 1'b0;
        check_eq("t1_fo_valid", 32'(Fo_valid),    32'h1);
        check_eq("t1_fo_rdata", Fo_rdata,         32'h13);
        check_eq("t1_stall",    32'(Fo_memStall), 32'h0);
        check_eq("t1_req_idle", 32'(mem_req),     32'h0);
        Fi_req = 1'b0;
        tick;
        check_eq("t1_fo_pulse", 32'(Fo_valid), 32'h0);

        // 2: simultaneous requests, M store served first
        Fi_req   = 1'b1;
        Fi_addr  = 32'h300;
        Mi_req   = 1'b1;
        Mi_we    = 1'b1;
        Mi_addr  = 32'h2000;
        Mi_wdata = 32'hDEAD_BEEF;
        Mi_be    = 4'b0011;
        tick;
        check_eq("t2_mem_we",    32'(mem_we),      32'h1);
        check_eq("t2_mem_addr",  mem_addr,         32'h2000);
        check_eq("t2_mem_wdata", mem_wdata,        32'hDEAD_BEEF);
        check_eq("t2_mem_be",    32'(mem_be),      32'h3);
        check_eq("t2_fstall_a",  32'(Fo_memStall), 32'h1);
        check_eq("t2_mstall_a",  32'(Mo_memStall), 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hA5A5_A5A5;
        tick;
        mem_ack = 1'b0;
        check_eq("t2_mo_valid",  32'(Mo_valid),    32'h1);
        check_eq("t2_mo_rdata",  Mo_rdata,         32'hA5A5_A5A5);
        check_eq("t2_mstall_b",  32'(Mo_memStall), 32'h0);
        check_eq("t2_fstall_b",  32'(Fo_memStall), 32'h1);
        check_eq("t2_fo_valid0", 32'(Fo_valid),    32'h0);
        Mi_req = 1'b0;
        Mi_we  = 1'b0;
        tick;
        check_eq("t2_f_grant",  32'(mem_req),     32'h1);
        check_eq("t2_f_addr",   mem_addr,         32'h300);
        check_eq("t2_f_we",     32'(mem_we),      32'h0);
        check_eq("t2_fstall_c", 32'(Fo_memStall), 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0055;
        tick;
        mem_ack = 1'b0;
        check_eq("t2_fo_valid", 32'(Fo_valid), 32'h1);
        check_eq("t2_fo_rdata", Fo_rdata,      32'h55);
        Fi_req = 1'b0;
        tick;

        // 3: fetch squashed by flush, then a redirected fetch
        Fi_req  = 1'b1;
        Fi_addr = 32'h104;
        tick;
        check_eq("t3_mem_addr", mem_addr, 32'h104);
        Fi_flush = 1'b1;
        tick;
        Fi_flush = 1'b0;
        Fi_addr  = 32'h200;
        tick;
        check_eq("t3_no_resample", mem_addr, 32'h104);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0BAD;
        tick;
        mem_ack = 1'b0;
        check_eq("t3_dropped",  32'(Fo_valid),    32'h0);
        check_eq("t3_rdata_kp", Fo_rdata,         32'h55);
        check_eq("t3_stall",    32'(Fo_memStall), 32'h1);
        tick;
        check_eq("t3_regrant",  32'(mem_req), 32'h1);
        check_eq("t3_new_addr", mem_addr,     32'h200);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0200_0013;
        tick;
        mem_ack = 1'b0;
        check_eq("t3_fo_valid", 32'(Fo_valid), 32'h1);
        check_eq("t3_fo_rdata", Fo_rdata,      32'h0200_0013);
        Fi_req = 1'b0;
        tick;

        // 4: load with no ack times out after 4 busy cycles, then retries
        Mi_req  = 1'b1;
        Mi_we   = 1'b0;
        Mi_addr = 32'h3000;
        Mi_be   = 4'hf;
        tick;
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_req && !mem_err) req_cycles++;
            tick;
        end
        check_eq("t4_req_cycles", 32'(req_cycles),  32'h4);
        check_eq("t4_req_drop",   32'(mem_req),     32'h0);
        check_eq("t4_mem_err",    32'(mem_err),     32'h1);
        check_eq("t4_no_valid",   32'(Mo_valid),    32'h0);
        check_eq("t4_stall_a",    32'(Mo_memStall), 32'h1);
        tick;
        check_eq("t4_reissue",    32'(mem_req),     32'h1);
        check_eq("t4_err_pulse",  32'(mem_err),     32'h0);
        check_eq("t4_re_addr",    mem_addr,         32'h3000);
        check_eq("t4_stall_b",    32'(Mo_memStall), 32'h1);
        tick;
        tick;
        tick;
        check_eq("t4_limit_req",  32'(mem_req), 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick;
        mem_ack = 1'b0;
        check_eq("t4_limit_ok",   32'(Mo_valid), 32'h1);
        check_eq("t4_limit_err",  32'(mem_err),  32'h0);
        check_eq("t4_limit_data", Mo_rdata,      32'h1234_5678);
        Mi_req = 1'b0;
        tick;

        // 5: asynchronous reset in the middle of an M access
        Mi_req   = 1'b1;
        Mi_we    = 1'b1;
        Mi_addr  = 32'h4000;
        Mi_wdata = 32'h0000_00FF;
        tick;
        check_eq("t5_busy", 32'(mem_req), 32'h1);
        #2 reset_x = 1'b0;
        #1;
        check_eq("t5_async_req",  32'(mem_req),  32'h0);
        check_eq("t5_async_mov",  32'(Mo_valid), 32'h0);
        check_eq("t5_async_err",  32'(mem_err),  32'h0);
        check_eq("t5_async_addr", mem_addr,      32'h0);
        tick;
        reset_x = 1'b1;
        check_eq("t5_idle",      32'(mem_req),     32'h0);
        check_eq("t5_stall",     32'(Mo_memStall), 32'h1);
        tick;
        check_eq("t5_reissue",   32'(mem_req), 32'h1);
        check_eq("t5_re_addr",   mem_addr,     32'h4000);
        check_eq("t5_re_we",     32'(mem_we),  32'h1);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        check_eq("t5_mo_valid",  32'(Mo_valid), 32'h1);
        Mi_req = 1'b0;
        Mi_we  = 1'b0;
        tick;

        // 6: back-to-back fetches with same-cycle ack
        txn_start = txn_count;
        Fi_req    = 1'b1;
        Fi_addr   = 32'h0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0011;
        tick;
        check_eq("t6_addr0",   mem_addr, 32'h0);
        tick;
        check_eq("t6_valid0",  32'(Fo_valid), 32'h1);
        check_eq("t6_rdata0",  Fo_rdata,      32'h11);
        check_eq("t6_nodup0",  32'(mem_req),  32'h0);
        Fi_addr   = 32'h4;
        mem_rdata = 32'h0000_0022;
        tick;
        check_eq("t6_gap",     32'(mem_req),  32'h0);
        check_eq("t6_gap_val", 32'(Fo_valid), 32'h0);
        tick;
        check_eq("t6_addr1",   mem_addr,     32'h4);
        check_eq("t6_req1",    32'(mem_req), 32'h1);
        tick;
        check_eq("t6_valid1",  32'(Fo_valid), 32'h1);
        check_eq("t6_rdata1",  Fo_rdata,      32'h22);
        check_eq("t6_nodup1",  32'(mem_req),  32'h0);
        Fi_req = 1'b0;
        tick;
        check_eq("t6_quiet_a", 32'(mem_req), 32'h0);
        tick;
        check_eq("t6_quiet_b", 32'(mem_req), 32'h0);
        check_eq("t6_txns",    32'(txn_count - txn_start), 32'h2);
        mem_ack = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
